// File: rtl/noc_params.sv
// Shared router definitions: port indices, flit labels and switch-allocator lock states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: PORT_NUM, port_t, flit_label_t, sa_lock_t.
package noc_params;

    localparam int PORT_NUM = 5;
    localparam int PORT_W   = 3;

    typedef logic [PORT_W-1:0] port_t;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef enum logic {
        SA_IDLE   = 1'b0,
        SA_LOCKED = 1'b1
    } sa_lock_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester found scanning upward from ptr, modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports: req (request vector), ptr (scan start) -> gnt (one-hot), vld (any grant).
module rr_arbiter
    import noc_params::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    input  port_t        ptr,
    output logic [N-1:0] gnt,
    output logic         vld
);

    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin with head-to-tail wormhole locking.
// Latency: grants are combinational from requests and registered state; state updates at the next edge.
// Backpressure: an output with on_off_i low grants nothing and keeps its lock and pointer.
// Ports: sa_request_i/out_port_i/flit_label_i per input, on_off_i per output ->
//        sa_valid_o per input, xb_valid_o/xb_sel_o per output.
// Optional: SWITCH_ALLOC_GRANT_CNT_EN adds parameter GRANT_CNT_W and per-output grant_cnt_o.
module switch_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM = noc_params::PORT_NUM
`ifdef SWITCH_ALLOC_GRANT_CNT_EN
    ,
    parameter int GRANT_CNT_W = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_NUM-1:0] sa_request_i,
    input  port_t               out_port_i   [PORT_NUM],
    input  flit_label_t         flit_label_i [PORT_NUM],
    input  logic [PORT_NUM-1:0] on_off_i,
    output logic [PORT_NUM-1:0] sa_valid_o,
    output logic [PORT_NUM-1:0] xb_valid_o,
    output port_t               xb_sel_o     [PORT_NUM]
`ifdef SWITCH_ALLOC_GRANT_CNT_EN
    ,
    output logic [GRANT_CNT_W-1:0] grant_cnt_o [PORT_NUM]
`endif
);

    sa_lock_t lock_q   [PORT_NUM];
    sa_lock_t lock_d   [PORT_NUM];
    port_t    owner_q  [PORT_NUM];
    port_t    owner_d  [PORT_NUM];
    port_t    rr_ptr_q [PORT_NUM];
    port_t    rr_ptr_d [PORT_NUM];

    logic [PORT_NUM-1:0] cand    [PORT_NUM];
    logic [PORT_NUM-1:0] arb_gnt [PORT_NUM];
    logic [PORT_NUM-1:0] arb_vld;
    logic [PORT_NUM-1:0] gnt_vld;
    port_t               gnt_idx [PORT_NUM];

    // cand[o][i]: input i wants output o this cycle.
    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                cand[o][i] = sa_request_i[i] && (out_port_i[i] == port_t'(o));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
        rr_arbiter #(.N(PORT_NUM)) u_rr_arbiter (
            .req (cand[o]),
            .ptr (rr_ptr_q[o]),
            .gnt (arb_gnt[o]),
            .vld (arb_vld[o])
        );
    end

    // A locked output ignores the arbiter and serves only its owner,
    // so a missing owner request leaves a bubble rather than a hand-over.
    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = '0;
            if (on_off_i[o]) begin
                if (lock_q[o] == SA_IDLE) begin
                    gnt_vld[o] = arb_vld[o];
                    for (int i = 0; i < PORT_NUM; i++) begin
                        if (arb_gnt[o][i]) gnt_idx[o] = port_t'(i);
                    end
                end else begin
                    gnt_vld[o] = cand[o][owner_q[o]];
                    gnt_idx[o] = owner_q[o];
                end
            end
        end
    end

    // Each input targets one output, so at most one output sets a given sa_valid_o bit.
    always_comb begin
        sa_valid_o = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            xb_valid_o[o] = 1'b0;
            xb_sel_o[o]   = '0;
            if (!rst && gnt_vld[o]) begin
                xb_valid_o[o]            = 1'b1;
                xb_sel_o[o]              = gnt_idx[o];
                sa_valid_o[gnt_idx[o]]   = 1'b1;
            end
        end
    end

    // Malformed labels fold into the nearest legal case: an idle output only
    // locks on HEAD, a locked output only releases on TAIL.
    always_comb begin
        lock_d   = lock_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (gnt_vld[o]) begin
                rr_ptr_d[o] = (gnt_idx[o] == port_t'(PORT_NUM - 1)) ? '0 : gnt_idx[o] + port_t'(1);
                if (lock_q[o] == SA_IDLE) begin
                    if (flit_label_i[gnt_idx[o]] == HEAD) begin
                        lock_d[o]  = SA_LOCKED;
                        owner_d[o] = gnt_idx[o];
                    end
                end else if (flit_label_i[gnt_idx[o]] == TAIL) begin
                    lock_d[o] = SA_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                lock_q[o]   <= SA_IDLE;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef SWITCH_ALLOC_GRANT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < PORT_NUM; o++) grant_cnt_o[o] <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (gnt_vld[o]) grant_cnt_o[o] <= grant_cnt_o[o] + GRANT_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed wormhole scenarios plus random traffic against a reference model.
// Latency: expects same-cycle grants and state updates at the following rising edge.
// Backpressure: on_off_i is randomised and also held low mid-packet.
module tb_switch_allocator;
    import noc_params::*;

    localparam int N  = 5;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    port_t          ports  [N];
    flit_label_t    labels [N];
    logic [N-1:0]   onoff;
    logic [N-1:0]   sa_valid;
    logic [N-1:0]   xb_valid;
    port_t          xb_sel [N];
`ifdef SWITCH_ALLOC_GRANT_CNT_EN
    logic [CW-1:0]  grant_cnt [N];
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per-output lock flag, owner, round-robin start, grant count.
    bit m_lock  [N];
    int m_owner [N];
    int m_ptr   [N];
    int m_cnt   [N];
    int exp_win [N];

`ifdef SWITCH_ALLOC_GRANT_CNT_EN
    switch_allocator #(.PORT_NUM(N), .GRANT_CNT_W(CW)) dut (
`else
    switch_allocator #(.PORT_NUM(N)) dut (
`endif
        .clk          (clk),
        .rst          (rst),
        .sa_request_i (req),
        .out_port_i   (ports),
        .flit_label_i (labels),
        .on_off_i     (onoff),
        .sa_valid_o   (sa_valid),
        .xb_valid_o   (xb_valid),
        .xb_sel_o     (xb_sel)
`ifdef SWITCH_ALLOC_GRANT_CNT_EN
        ,
        .grant_cnt_o  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_lock[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0; m_cnt[o] = 0;
        end
    endtask

    task automatic idle_inputs();
        req = '0;
        onoff = '1;
        for (int i = 0; i < N; i++) begin
            ports[i] = '0; labels[i] = HEADTAIL;
        end
    endtask

    function automatic bit wants(int i, int o);
        return req[i] && (int'(ports[i]) == o);
    endfunction

    // Called at posedge+1 after inputs are driven; compares this cycle's grants.
    task automatic cyc_check(input string tag);
        logic [N-1:0] exp_sa, exp_xv;
        #2;
        exp_sa = '0; exp_xv = '0;
        for (int o = 0; o < N; o++) begin
            exp_win[o] = -1;
            if (onoff[o]) begin
                if (m_lock[o]) begin
                    if (wants(m_owner[o], o)) exp_win[o] = m_owner[o];
                end else begin
                    for (int k = N - 1; k >= 0; k--) begin
                        if (wants((m_ptr[o] + k) % N, o)) exp_win[o] = (m_ptr[o] + k) % N;
                    end
                end
            end
            if (exp_win[o] >= 0) begin
                exp_sa[exp_win[o]] = 1'b1;
                exp_xv[o] = 1'b1;
            end
        end
        check_val({tag, ".sa_valid"}, 32'(sa_valid), 32'(exp_sa));
        check_val({tag, ".xb_valid"}, 32'(xb_valid), 32'(exp_xv));
        for (int o = 0; o < N; o++) begin
            check_val($sformatf("%s.xb_sel%0d", tag, o), 32'(xb_sel[o]),
                      32'((exp_win[o] >= 0) ? exp_win[o] : 0));
`ifdef SWITCH_ALLOC_GRANT_CNT_EN
            check_val($sformatf("%s.cnt%0d", tag, o), 32'(grant_cnt[o]), 32'(m_cnt[o]));
`endif
        end
    endtask

    // Advances to the next edge and applies the granted flits to the model.
    task automatic cyc_commit();
        @(posedge clk);
        for (int o = 0; o < N; o++) begin
            if (exp_win[o] >= 0) begin
                m_ptr[o] = (exp_win[o] + 1) % N;
                m_cnt[o] = (m_cnt[o] + 1) % (1 << CW);
                if (!m_lock[o]) begin
                    if (labels[exp_win[o]] == HEAD) begin
                        m_lock[o] = 1'b1; m_owner[o] = exp_win[o];
                    end
                end else if (labels[exp_win[o]] == TAIL) begin
                    m_lock[o] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic step(input string tag);
        cyc_check(tag);
        cyc_commit();
    endtask

    // Pulses reset for part of a cycle with inputs still active; outputs must read 0.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_val({tag, ".sa_valid"}, 32'(sa_valid), 32'd0);
        check_val({tag, ".xb_valid"}, 32'(xb_valid), 32'd0);
        for (int o = 0; o < N; o++) check_val($sformatf("%s.xb_sel%0d", tag, o), 32'(xb_sel[o]), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        req = 5'b11111;
        for (int i = 0; i < N; i++) ports[i] = port_t'((i + 1) % N);
        model_reset();
        #3;
        check_val("init.sa_valid", 32'(sa_valid), 32'd0);
        check_val("init.xb_valid", 32'(xb_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;

        // Two HEADTAIL senders sharing output 2 alternate 1,3,1,3.
        req = 5'b01010; ports[1] = 3'd2; ports[3] = 3'd2;
        for (int c = 0; c < 4; c++) begin
            cyc_check("s1");
            check_val("s1.sel2", 32'(xb_sel[2]), (c % 2 == 0) ? 32'd1 : 32'd3);
            cyc_commit();
        end

        // Input 0 holds output 4 for a full packet; input 2 waits until cycle 5.
        idle_inputs();
        req = 5'b00101; ports[0] = 3'd4; ports[2] = 3'd4;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) req[0] = 1'b0;
            labels[0] = (c == 0) ? HEAD : (c == 3) ? TAIL : BODY;
            cyc_check("s2");
            check_val("s2.sa_valid", 32'(sa_valid), (c < 4) ? 32'h01 : 32'h04);
            cyc_commit();
        end

        // Output 3 locked to input 1 stalls three cycles under on_off low, then resumes.
        idle_inputs();
        req = 5'b10010; ports[1] = 3'd3; ports[4] = 3'd3;
        labels[1] = HEAD; labels[4] = HEADTAIL;
        step("s3.head");
        labels[1] = BODY;
        onoff[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc_check("s3.stall");
            check_val("s3.stall.xv3", 32'(xb_valid[3]), 32'd0);
            cyc_commit();
        end
        onoff[3] = 1'b1;
        cyc_check("s3.body");
        check_val("s3.body.sel3", 32'(xb_sel[3]), 32'd1);
        check_val("s3.body.sa", 32'(sa_valid), 32'h02);
        cyc_commit();
        labels[1] = TAIL;
        step("s3.tail");
        req[1] = 1'b0;
        cyc_check("s3.after");
        check_val("s3.after.sa", 32'(sa_valid), 32'h10);
        cyc_commit();

        // Full permutation: every input and output served in one cycle.
        idle_inputs();
        req = 5'b11111;
        for (int i = 0; i < N; i++) ports[i] = port_t'((i + 1) % N);
        cyc_check("s4");
        check_val("s4.sa_all", 32'(sa_valid), 32'h1f);
        check_val("s4.xv_all", 32'(xb_valid), 32'h1f);
        cyc_commit();

        // Reset mid-packet drops the lock held by input 4 on output 2.
        idle_inputs();
        req = 5'b10000; ports[4] = 3'd2; labels[4] = HEAD;
        step("s5.head");
        labels[4] = BODY;
        do_reset("s5.rst");
        idle_inputs();
        req = 5'b00001; ports[0] = 3'd2; labels[0] = HEAD;
        cyc_check("s5.new");
        check_val("s5.new.xv2", 32'(xb_valid[2]), 32'd1);
        check_val("s5.new.sa", 32'(sa_valid), 32'h01);
        cyc_commit();

`ifdef SWITCH_ALLOC_GRANT_CNT_EN
        // 17 grants on a 4-bit counter wrap to 1.
        idle_inputs();
        do_reset("s6.rst");
        req = 5'b00001; ports[0] = 3'd0;
        for (int c = 0; c < 17; c++) step("s6");
        check_val("s6.cnt0_wrap", 32'(grant_cnt[0]), 32'd1);
`endif

        // Random traffic, including malformed label sequences and occasional resets.
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                ports[i]  = port_t'($urandom_range(0, N - 1));
                labels[i] = flit_label_t'($urandom_range(0, 3));
                onoff[i]  = ($urandom_range(0, 9) < 8);
            end
            if ($urandom_range(0, 99) == 0) do_reset("rnd.rst");
            else step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
